stream_sync_fifo: RTL and testbench

- Synchronous valid/ready FIFO that buffers a data stream directly upstream of register_slice. Its output handshake (o_valid/o_data/i_ready) connects straight to the slice's i_valid/i_data/o_ready.
- Absorbs downstream back-pressure for up to DEPTH beats so that producer bursts are not stalled.
- Single clock domain, no width conversion.

---
 rtl/stream_pkg.sv | 17 +
 rtl/stream_fifo_ptr.sv | 35 +++
 rtl/stream_sync_fifo.sv | 106 ++++++++++
 tb/tb_stream_sync_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream-path definitions: payload width default and FIFO pointer sizing helpers.
package stream_pkg;

  // Default payload width shared by the FIFO and the downstream register slice.
  localparam int unsigned STREAM_DATA_WIDTH = 32;

  // Pointer width for a wrap-bit FIFO: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two (zero excluded).
  function automatic bit is_pow2(input int unsigned depth);
    return (depth != 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrap-bit FIFO pointer: AW index bits plus an MSB that toggles every time the index wraps.
module stream_fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [AW:0] o_ptr
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // Next pointer: advance by one when enabled; the carry into the MSB is the wrap toggle.
  always_comb begin
    // NOTE: default first so every path assigns ptr_d and no latch is inferred.
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = ptr_q + (AW + 1)'(1);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/stream_sync_fifo.sv
// Synchronous valid/ready FIFO feeding register_slice.
// Optional macro STREAM_SYNC_FIFO_BYPASS_EN: when empty, an incoming beat is presented
// combinationally on the output and, if taken in the same cycle, never written.
import stream_pkg::*;

module stream_sync_fifo #(
  parameter  int unsigned DATA_WIDTH = STREAM_DATA_WIDTH,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [AW:0]           o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  if (DEPTH < 2 || !is_pow2(DEPTH) || ptr_width(DEPTH) != AW + 1) begin : g_bad_depth
    $error("stream_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic          wrap;
    logic [AW-1:0] idx;
  } ptr_t;

  logic [AW:0] wptr_raw;
  logic [AW:0] rptr_raw;
  ptr_t        wptr;
  ptr_t        rptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        wr_en;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  assign wptr  = ptr_t'(wptr_raw);
  assign rptr  = ptr_t'(rptr_raw);
  assign empty = (wptr == rptr);
  assign full  = (wptr.idx == rptr.idx) && (wptr.wrap != rptr.wrap);

  assign o_ready = !full;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = wptr_raw - rptr_raw;
  assign push    = i_valid && o_ready;

`ifdef STREAM_SYNC_FIFO_BYPASS_EN
  logic bypass;
  // An empty FIFO forwards the incoming beat; a beat taken on the spot never touches storage.
  assign bypass  = empty && i_valid && i_ready;
  assign o_valid = !empty || i_valid;
  assign o_data  = empty ? i_data : mem_q[rptr.idx];
  assign pop     = !empty && i_ready;
  assign wr_en   = push && !bypass;
`else
  assign o_valid = !empty;
  assign o_data  = mem_q[rptr.idx];
  assign pop     = o_valid && i_ready;
  assign wr_en   = push;
`endif

  stream_fifo_ptr #(.AW(AW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en),
    .o_ptr (wptr_raw)
  );

  stream_fifo_ptr #(.AW(AW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop),
    .o_ptr (rptr_raw)
  );

  // Next storage contents: write the accepted beat at the write index.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wptr.idx] = i_data;
    end
  end

  // Storage array, cleared on reset so o_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset deliberately; a zero head payload after reset is part of the interface.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_stream_sync_fifo.sv
// Self-checking bench for stream_sync_fifo (DEPTH=4, DATA_WIDTH=32).
// A queue model tracks what the FIFO must hold; a per-cycle compare checks all outputs
// against it, and directed phases add hand-computed literal expectations.
module tb_stream_sync_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q[$];

  stream_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO is a queue; accept when fewer than DEPTH held, release head when asked.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      int sz;
      bit take;
      bit give;
      sz = model_q.size();
`ifdef STREAM_SYNC_FIFO_BYPASS_EN
      if (sz == 0 && i_valid && i_ready) begin
        take = 1'b0;
        give = 1'b0;
      end else begin
        take = i_valid && (sz < DEPTH);
        give = (sz > 0) && i_ready;
      end
`else
      take = i_valid && (sz < DEPTH);
      give = (sz > 0) && i_ready;
`endif
      if (give) void'(model_q.pop_front());
      if (take) model_q.push_back(i_data);
    end
  end

  // Per-cycle compare of every output against the model, mid-cycle.
  always @(negedge clk) begin
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            sz;
    sz = model_q.size();
    exp_valid = (sz != 0);
    exp_data  = (sz != 0) ? model_q[0] : '0;
`ifdef STREAM_SYNC_FIFO_BYPASS_EN
    if (sz == 0 && i_valid && rst_n) begin
      exp_valid = 1'b1;
      exp_data  = i_data;
    end
`endif
    check("cmp_valid", 64'(o_valid), 64'(exp_valid));
    if (exp_valid) check("cmp_data", 64'(o_data), 64'(exp_data));
    check("cmp_count", 64'(o_count), 64'(sz));
    check("cmp_full",  64'(o_full),  64'(sz == DEPTH));
    check("cmp_empty", 64'(o_empty), 64'(sz == 0));
    check("cmp_ready", 64'(o_ready), 64'(sz != DEPTH));
  end

  initial begin
    logic [DW-1:0] fill_vals [4];
    fill_vals[0] = 32'h11; fill_vals[1] = 32'h22; fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;

    // Reset held two cycles, then idle.
    rst_n = 1'b0;
    step(); step();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_valid", 64'(o_valid), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd1);
    check("idle_empty", 64'(o_empty), 64'd1);
    check("idle_count", 64'(o_count), 64'd0);
    check("idle_data",  64'(o_data),  64'd0);

    // Fill with downstream stalled.
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = fill_vals[k];
      step();
      check("fill_count", 64'(o_count), 64'(k + 1));
    end
    check("fill_full",  64'(o_full),  64'd1);
    check("fill_ready", 64'(o_ready), 64'd0);
    i_data = 32'h55;
    step(); step();
    check("over_count", 64'(o_count), 64'd4);
    check("over_head",  64'(o_data),  64'h11);

    // Drain in order.
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_data", 64'(o_data), 64'(fill_vals[k]));
      step();
    end
    check("drain_valid", 64'(o_valid), 64'd0);
    check("drain_empty", 64'(o_empty), 64'd1);

    // Two stored, then ten cycles of simultaneous push and pop.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data = 32'hA0; step();
    i_data = 32'hA1; step();
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_data = 32'h100 + 32'(k);
      #1;
      check("pp_data", 64'(o_data), (k < 2) ? 64'(32'hA0 + 32'(k)) : 64'(32'h100 + 32'(k - 2)));
      step();
      check("pp_count", 64'(o_count), 64'd2);
    end
    i_valid = 1'b0;
    check("pp_tail0", 64'(o_data), 64'h108);
    step();
    check("pp_tail1", 64'(o_data), 64'h109);
    step();
    check("pp_empty", 64'(o_empty), 64'd1);

    // Async reset mid-stream with three stored.
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = 32'h200 + 32'(k);
      step();
    end
    i_valid = 1'b0;
    check("ar_pre_count", 64'(o_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(o_valid), 64'd0);
    check("ar_count", 64'(o_count), 64'd0);
    check("ar_data",  64'(o_data),  64'd0);
    step(); step();
    rst_n = 1'b1;
    i_valid = 1'b1;
    i_data = 32'hDEADBEEF; step();
    i_data = 32'h00001234; step();
    i_valid = 1'b0;
    check("ar_first", 64'(o_data), 64'hDEADBEEF);
    i_ready = 1'b1;
    step();
    check("ar_second", 64'(o_data), 64'h1234);
    step();
    check("ar_empty", 64'(o_empty), 64'd1);

    // Beat into an empty FIFO with downstream ready.
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 32'hCAFEBABE;
    #1;
`ifdef STREAM_SYNC_FIFO_BYPASS_EN
    check("byp_valid", 64'(o_valid), 64'd1);
    check("byp_data",  64'(o_data),  64'hCAFEBABE);
    check("byp_count", 64'(o_count), 64'd0);
    step();
    i_valid = 1'b0;
    #1;
    check("byp_after_valid", 64'(o_valid), 64'd0);
    check("byp_after_count", 64'(o_count), 64'd0);
`else
    check("nobyp_valid", 64'(o_valid), 64'd0);
    step();
    i_valid = 1'b0;
    #1;
    check("nobyp_next_valid", 64'(o_valid), 64'd1);
    check("nobyp_next_data",  64'(o_data),  64'hCAFEBABE);
    step();
    check("nobyp_drained", 64'(o_valid), 64'd0);
`endif
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
